// File: rtl/alu_pkg.sv
// alu_pkg: types shared by the alu issue queue, its FIFO and the testbench.
//   DATA_W    - operand width (alu in1/in2)
//   OP_W      - opcode width (alu op)
//   alu_op_e  - opcode encoding
//   alu_req_t - one queued request {in1, in2, op}
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        alu_op_e           op;
    } alu_req_t;

    localparam int REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: valid/ready channel carrying one alu request.
//   data  - request payload {in1, in2, op}
//   valid - payload valid (driven by master)
//   ready - sink can accept (driven by slave)
// A transfer happens on a rising clock edge where valid && ready.
interface alu_issue_queue_if;
    import alu_pkg::*;

    alu_req_t data;
    logic     valid;
    logic     ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/alu_issue_queue_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count.
//   clk, rst         - clock, asynchronous active-high reset
//   wr_en, wr_data   - push (ignored while full)
//   rd_en            - pop the head (ignored while empty)
//   rd_data          - current head entry, valid whenever !empty
//   count            - entries held, 0..DEPTH
//   full, empty      - occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are meaningful, so resetting the array buys nothing.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers producer requests and issues them in order to
// the alu, limiting the number of ops in flight to MAX_OUT.
//   clk, rst       - clock, asynchronous active-high reset
//   req (slave)    - producer request channel (req_in1/in2/op/valid/ready)
//   alu (master)   - alu input channel (in1/in2/op/in_valid/in_ready)
//   alu_out_valid,
//   alu_out_ready  - observed alu result handshake; each transfer retires
//                    one in-flight op
//   count          - entries held in the queue
//   outstanding    - ops issued but not yet retired
//   err            - sticky: a result was seen with nothing in flight
// Build option ALU_ISSUE_BYPASS_EN: with an empty queue and a free credit,
// a request is forwarded combinationally to the alu in the same cycle.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int MAX_OUT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_issue_queue_if.slave           req,
    alu_issue_queue_if.master          alu,
    input  logic                       alu_out_valid,
    input  logic                       alu_out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err
);
    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    alu_req_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_wr;
    logic     fifo_rd;
    logic     credit_ok;
    logic     enq;
    logic     iss;
    logic     ret;

    assign credit_ok = (outstanding < OUT_W'(MAX_OUT));

    // No enqueue while full, even if the head issues this cycle.
    assign req.ready = ~rst & ~fifo_full;

    assign enq = req.valid & req.ready;
    assign iss = alu.valid & alu.ready;
    assign ret = alu_out_valid & alu_out_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    logic bypass;

    // Empty queue with a free credit: the producer talks straight to the alu.
    assign bypass    = fifo_empty & credit_ok;
    assign alu.valid = ~rst & (bypass ? req.valid : (~fifo_empty & credit_ok));
    assign alu.data  = ~alu.valid ? '0 : (bypass ? req.data : head);
    // A bypassed request that the alu takes immediately never lands in the FIFO.
    assign fifo_wr   = enq & ~(bypass & alu.ready);
    assign fifo_rd   = iss & ~bypass;
`else
    // Valid and payload come only from registered state; the payload is
    // zeroed while nothing is offered so idle/reset reads are defined.
    assign alu.valid = ~rst & ~fifo_empty & credit_ok;
    assign alu.data  = alu.valid ? head : '0;
    assign fifo_wr   = enq;
    assign fifo_rd   = iss;
`endif

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (req.data),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // In-flight tracking. A result with nothing in flight is a protocol
    // error: the counter is held at zero rather than allowed to wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (ret && (outstanding == '0))
                err <= 1'b1;
            case ({iss, ret})
                2'b10: outstanding <= outstanding + 1'b1;
                2'b01: if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed bench for alu_issue_queue (default build,
// DEPTH = 8, MAX_OUT = 2). Accepted requests are pushed to a scoreboard
// queue; a monitor pops and compares on every alu issue handshake.
// A small alu model returns one result per issued op a cycle later when
// auto_ret is set; ret_next injects extra (possibly spurious) results.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DEPTH   = 8;
    localparam int MAX_OUT = 2;

    logic                       clk;
    logic                       rst;
    logic                       alu_out_valid;
    logic                       alu_out_ready;
    logic [$clog2(DEPTH):0]     count;
    logic [$clog2(MAX_OUT):0]   outstanding;
    logic                       err;

    alu_issue_queue_if req_if ();
    alu_issue_queue_if alu_if ();

    alu_issue_queue #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req_if),
        .alu           (alu_if),
        .alu_out_valid (alu_out_valid),
        .alu_out_ready (alu_out_ready),
        .count         (count),
        .outstanding   (outstanding),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int       n_checks = 0;
    int       n_fail   = 0;
    alu_req_t exp_q[$];
    logic     iss_seen;
    bit       auto_ret;
    int       ret_next;
    int       ret_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every issue handshake must carry the oldest accepted request.
    always @(negedge clk) begin
        if (!rst && alu_if.valid && alu_if.ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_order: got issue %0h, expected no issue (t=%0t)",
                         alu_if.data, $time);
            end else begin
                check("issue_payload", alu_if.data, exp_q.pop_front());
            end
        end
    end

    // Sample phase: DUT outputs are stable at the falling edge.
    task automatic sample();
        @(negedge clk);
        iss_seen = alu_if.valid & alu_if.ready;
    endtask

    // Advance past the next rising edge and drive the alu result model.
    task automatic adv();
        @(posedge clk);
        #1;
        if (auto_ret && iss_seen)
            ret_cnt++;
        ret_cnt  += ret_next;
        ret_next  = 0;
        iss_seen  = 1'b0;
        if (ret_cnt > 0) begin
            alu_out_valid = 1'b1;
            ret_cnt--;
        end else begin
            alu_out_valid = 1'b0;
        end
        alu_out_ready = alu_out_valid;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input alu_op_e op,
                        input logic expect_acc);
        req_if.data  = '{in1: a, in2: b, op: op};
        req_if.valid = 1'b1;
        sample();
        check("req_ready_on_push", req_if.ready, expect_acc);
        if (req_if.ready)
            exp_q.push_back(req_if.data);
        adv();
        req_if.valid = 1'b0;
    endtask

    // Run until queue and in-flight count are both empty, bounded.
    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            sample();
            done = (count == '0) && (outstanding == '0);
            adv();
        end
        check("drain_done", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        req_if.data   = '0;
        req_if.valid  = 1'b0;
        alu_if.ready  = 1'b0;
        alu_out_valid = 1'b0;
        alu_out_ready = 1'b0;
        iss_seen      = 1'b0;
        auto_ret      = 1'b0;
        ret_next      = 0;
        ret_cnt       = 0;

        // ---- reset then idle
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_if.ready, 1'b0);
        check("rst_alu_valid", alu_if.valid, 1'b0);
        check("rst_alu_payload", alu_if.data, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("idle_req_ready", req_if.ready, 1'b1);
        check("idle_alu_valid", alu_if.valid, 1'b0);
        check("idle_count", count, 0);
        check("idle_outstanding", outstanding, 0);
        check("idle_err", err, 1'b0);
        adv();

        // ---- single op, alu always ready, result one cycle later
        alu_if.ready = 1'b1;
        auto_ret     = 1'b1;
        push(32'd5, 32'd3, OP_ADD, 1'b1);
        sample();
        check("single_valid_next_cycle", alu_if.valid, 1'b1);
        check("single_in1", alu_if.data.in1, 32'd5);
        check("single_in2", alu_if.data.in2, 32'd3);
        check("single_count", count, 1);
        check("single_out0", outstanding, 0);
        adv();
        sample();
        check("single_out1", outstanding, 1);
        check("single_valid_after_iss", alu_if.valid, 1'b0);
        adv();
        sample();
        check("single_out_back0", outstanding, 0);
        adv();

        // ---- fill to full with the alu stalled
        alu_if.ready = 1'b0;
        auto_ret     = 1'b0;
        for (int i = 0; i < 8; i++)
            push(32'(i), 32'h100 + 32'(i), alu_op_e'(4'(i)), 1'b1);
        sample();
        check("full_count", count, 8);
        check("full_req_ready", req_if.ready, 1'b0);
        check("full_alu_valid", alu_if.valid, 1'b1);
        adv();
        push(32'd99, 32'd99, OP_SUB, 1'b0);
        sample();
        check("full_no_enq", count, 8);
        adv();
        alu_if.ready = 1'b1;
        auto_ret     = 1'b1;
        drain();
        check("fill_scoreboard_empty", exp_q.size(), 0);

        // ---- credit throttle: four ops, no results returned
        auto_ret = 1'b0;
        push(32'd10, 32'd1, OP_ADD, 1'b1);
        push(32'd20, 32'd2, OP_SUB, 1'b1);
        push(32'd30, 32'd3, OP_AND, 1'b1);
        push(32'd40, 32'd4, OP_OR,  1'b1);
        sample();
        check("thr_count", count, 2);
        check("thr_outstanding", outstanding, 2);
        check("thr_valid_low", alu_if.valid, 1'b0);
        adv();
        sample();
        check("thr_valid_still_low", alu_if.valid, 1'b0);
        check("thr_count_held", count, 2);
        ret_next = 1;
        adv();
        sample();
        check("thr_ret_pending", alu_out_valid, 1'b1);
        check("thr_out_before_ret", outstanding, 2);
        adv();
        sample();
        check("thr_third_valid", alu_if.valid, 1'b1);
        check("thr_out_after_ret", outstanding, 1);
        adv();
        sample();
        check("thr_out_refill", outstanding, 2);
        check("thr_count_after_iss", count, 1);
        adv();

        // ---- simultaneous enq+iss at count 3, iss+ret at outstanding 1
        push(32'd50, 32'd5, OP_XOR, 1'b1);
        push(32'd60, 32'd6, OP_SLL, 1'b1);
        sample();
        check("sim_pre_count", count, 3);
        check("sim_pre_out", outstanding, 2);
        ret_next = 1;
        adv();
        sample();
        check("sim_y1_out", outstanding, 2);
        ret_next = 1;
        adv();
        req_if.data  = '{in1: 32'd70, in2: 32'd7, op: OP_SRL};
        req_if.valid = 1'b1;
        sample();
        check("sim_y2_ready", req_if.ready, 1'b1);
        check("sim_y2_valid", alu_if.valid, 1'b1);
        check("sim_y2_ret", alu_out_valid, 1'b1);
        check("sim_y2_count", count, 3);
        check("sim_y2_out", outstanding, 1);
        exp_q.push_back(req_if.data);
        adv();
        req_if.valid = 1'b0;
        sample();
        check("sim_count_held", count, 3);
        check("sim_out_held", outstanding, 1);
        auto_ret = 1'b1;
        ret_next = 1;
        adv();
        drain();
        check("sim_scoreboard_empty", exp_q.size(), 0);
        check("sim_err_clear", err, 1'b0);

        // ---- spurious result with nothing in flight
        ret_next = 1;
        sample();
        adv();
        sample();
        check("spur_err_before", err, 1'b0);
        adv();
        sample();
        check("spur_err_set", err, 1'b1);
        check("spur_out_zero", outstanding, 0);
        adv();
        repeat (3) begin
            sample();
            adv();
        end
        sample();
        check("spur_err_sticky", err, 1'b1);
        adv();

        // ---- reset in the middle of a burst
        auto_ret = 1'b0;
        push(32'd1, 32'd1, OP_ADD, 1'b1);
        push(32'd2, 32'd2, OP_ADD, 1'b1);
        push(32'd3, 32'd3, OP_ADD, 1'b1);
        req_if.data  = '{in1: 32'd4, in2: 32'd4, op: OP_ADD};
        req_if.valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_out", outstanding, 0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_req_ready", req_if.ready, 1'b0);
        check("mid_rst_alu_valid", alu_if.valid, 1'b0);
        exp_q.delete();
        ret_cnt      = 0;
        ret_next     = 0;
        iss_seen     = 1'b0;
        req_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("post_rst_req_ready", req_if.ready, 1'b1);
        check("post_rst_count", count, 0);
        check("post_rst_alu_valid", alu_if.valid, 1'b0);
        adv();

        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
